// File: rtl/console_uart_tx_pkg.sv
// console_uart_tx_pkg: shared encodings for the console UART transmit path.
// Rev 1.0
`default_nettype none

package console_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;

  localparam logic [31:0] CON_ADDR = 32'hFFFF_FFF1;

  function automatic logic [31:0] status_word(input logic busy, input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[STAT_BUSY]  = busy;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/console_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/console_uart_tx.sv
// console_uart_tx: Wishbone console slave that serializes written bytes as 8N1 UART.
// Rev 1.0
`default_nettype none

module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_ack;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_busy;
  logic              w_baud_done;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [7:0]        w_fifo_data;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_unused;

  assign w_unused = ^{i_wb_data[31:8], w_fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_wb_data[7:0]),
    .o_rdata (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // Only writes can stall; full comes from the registered count, so a pop this cycle does not help.
  assign o_wb_stall  = i_wb_stb & i_wb_we & w_fifo_full;
  assign w_accept    = i_wb_stb & ~o_wb_stall;
  assign w_push      = w_accept & i_wb_we;
  assign w_busy      = (r_state != UART_IDLE);
  assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  assign o_wb_ack  = r_ack;
  assign o_wb_data = r_rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= (w_accept & ~i_wb_we) ? status_word(w_busy, w_fifo_full, w_fifo_empty) : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    o_tx         = 1'b1;
    case (r_state)
      UART_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = UART_START;
        end
      end
      UART_START: begin
        o_tx = 1'b0;
        if (w_baud_done) w_state_next = UART_DATA;
      end
      UART_DATA: begin
        o_tx = r_shift[0];
        if (w_baud_done && (r_bit == 3'd7)) w_state_next = UART_STOP;
      end
      UART_STOP: begin
        if (w_baud_done) w_state_next = UART_IDLE;
      end
      default: w_state_next = UART_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= UART_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if ((r_state == UART_IDLE) || (w_state_next != r_state) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (w_pop) begin
        r_shift <= w_fifo_data;
        r_bit   <= '0;
      end else if ((r_state == UART_DATA) && w_baud_done) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: scoreboard bench with a line-level UART receiver model.
// Rev 1.0
`default_nettype none

module tb_console_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] dat;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] dat = '0;
  logic [31:0] o_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic        o_tx;

  int          cycle = 0;
  int          errors = 0;
  int          checks = 0;
  ack_t        ack_q[$];
  logic [7:0]  byte_q[$];
  int          start_q[$];
  ack_t        a_m;

  console_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_data  (dat),
    .o_wb_data  (o_wb_data),
    .o_wb_ack   (o_wb_ack),
    .o_wb_stall (o_wb_stall),
    .o_tx       (o_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cycle);
  endtask

  // Issue one request, holding it through stalls; returns after the accepting edge.
  task automatic wb_req(input bit w, input logic [31:0] d, input logic [31:0] exp_rd,
                        output int n_acc, output int n_stall);
    ack_t a;
    @(negedge clk);
    stb = 1'b1; we = w; dat = d; n_stall = 0; n_acc = -1;
    #1;
    while (o_wb_stall && n_stall < 2000) begin
      @(negedge clk); #1;
      n_stall++;
    end
    if (o_wb_stall) begin
      fail_now("request_stall_timeout");
      stb = 1'b0;
    end else begin
      n_acc = cycle;
      a.cyc = cycle + 1; a.rd = !w; a.dat = exp_rd;
      ack_q.push_back(a);
      if (w) byte_q.push_back(d[7:0]);
      @(posedge clk); #1;
      stb = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (byte_q.size() > 0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (byte_q.size() > 0) fail_now("drain_timeout");
  endtask

  // Ack scoreboard
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (ack_q.size() > 0 && ack_q[0].cyc < cycle) begin
          fail_now("missing_ack");
          void'(ack_q.pop_front());
        end
        if (o_wb_ack) begin
          if (ack_q.size() == 0) begin
            fail_now("unexpected_ack");
          end else begin
            a_m = ack_q.pop_front();
            chk("ack_cycle", cycle, a_m.cyc);
            chk(a_m.rd ? "status_read" : "write_ack_data", o_wb_data, a_m.dat);
          end
        end
      end
    end
  end

  // Line receiver: samples each bit at its centre
  initial begin
    int         s;
    logic [7:0] b;
    bit         ab;
    b = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && o_tx === 1'b0) begin
        s  = cycle;
        ab = 1'b0;
        start_q.push_back(s);
        for (int k = 0; k < 10 && !ab; k++) begin
          while (cycle < s + k * CPB + CPB / 2 && !rst) begin
            @(posedge clk); #1;
          end
          if (rst) ab = 1'b1;
          else if (k == 0) chk("start_bit", o_tx, 0);
          else if (k < 9) b[k-1] = o_tx;
          else chk("stop_bit", o_tx, 1);
        end
        if (!ab) begin
          if (byte_q.size() == 0) fail_now("unexpected_frame");
          else chk("rx_byte", b, byte_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    fail_now("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int         n, st, base, n0, e, idx;
    int         acc[6];
    int         stl[6];
    logic [9:0] frame;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_tx", o_tx, 1);
    chk("idle_ack", o_wb_ack, 0);
    chk("idle_stall", o_wb_stall, 0);
    chk("idle_rdata", o_wb_data, 0);
    wb_req(1'b0, 32'h0, 32'h1, n, st);

    // Single byte: exact line shape and latency
    wb_req(1'b1, 32'h0000_00A5, 32'h0, n, st);
    frame = {1'b1, 8'hA5, 1'b0};
    while (cycle <= n + 42) begin
      if (cycle >= n + 2 && cycle <= n + 41) begin
        idx = (cycle - n - 2) / CPB;
        e = frame[idx];
      end else begin
        e = 1;
      end
      chk("a5_line", o_tx, e);
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);

    // Back-to-back 0x11..0x16 through a 4-deep FIFO
    base = start_q.size();
    for (int i = 0; i < 6; i++) begin
      wb_req(1'b1, 32'h11 + i, 32'h0, acc[i], stl[i]);
    end
    for (int i = 0; i < 5; i++) chk("b2b_no_stall", stl[i], 0);
    if (start_q.size() > base) begin
      chk("b2b_first_start", start_q[base], acc[0] + 2);
      chk("b2b_6th_accept", acc[5], start_q[base] + 10 * CPB + 1);
    end else begin
      fail_now("b2b_no_frame");
    end
    wait_drain(3000);
    repeat (4) @(posedge clk);
    if (start_q.size() >= base + 6) begin
      for (int i = 1; i < 6; i++) begin
        chk("b2b_frame_period", start_q[base+i] - start_q[base+i-1], 10 * CPB + 1);
      end
    end else begin
      fail_now("b2b_frame_count");
    end

    // Fill, poll status while busy, then after drain
    for (int i = 0; i < 5; i++) wb_req(1'b1, $urandom, 32'h0, n, st);
    wb_req(1'b0, 32'h0, 32'h6, n, st);
    wait_drain(3000);
    repeat (4) @(posedge clk);
    wb_req(1'b0, 32'h0, 32'h1, n, st);
    repeat (3) @(posedge clk);

    // Reset during the third data bit of 0x41
    wb_req(1'b1, 32'h0000_0041, 32'h0, n, st);
    while (cycle < n + 2 + 3 * CPB + 1) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_tx", o_tx, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_tx_immediate", o_tx, 1);
    byte_q.delete();
    ack_q.delete();
    n0 = start_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("no_frame_after_reset", start_q.size(), n0);
    wb_req(1'b0, 32'h0, 32'h1, n, st);

    // Upper data bits ignored
    wb_req(1'b1, 32'hFFFF_FF80, 32'h0, n, st);
    wait_drain(1000);

    // Random writes with random spacing
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 60)) @(posedge clk);
      wb_req(1'b1, $urandom, 32'h0, n, st);
    end
    wait_drain(5000);
    repeat (6) @(posedge clk);
    #1;
    chk("acks_outstanding", ack_q.size(), 0);
    chk("final_tx_idle", o_tx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
